uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 151 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 8N1 UART transmitter; define UART_TX_FIFO_EN for a FIFO_DEPTH byte buffer
module uart_tx_fifo #(
   parameter int CLOCK_DIVIDER = 417,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   output logic       tx,
   output logic       busy
);
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   localparam logic [15:0] DIV_LAST = 16'(CLOCK_DIVIDER - 1);

   generate
      if (CLOCK_DIVIDER < 2 || CLOCK_DIVIDER > 65535 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
          (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
         $error("uart_tx_fifo: illegal CLOCK_DIVIDER or FIFO_DEPTH");
      end
   endgenerate

   state_t      state_q, state_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        tx_q, tx_d;
   logic        run_q;
   logic        baud_tc;
   logic        src_valid;
   logic [7:0]  src_data;
   logic        stored;
   logic        load;

`ifdef UART_TX_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;
   logic          full;
   logic          push;

   // ready stays low on a full FIFO even when this cycle pops, keeping valid->ready registered
   assign full      = (cnt_q == (AW + 1)'(FIFO_DEPTH));
   assign ready     = run_q && !full;
   assign push      = valid && ready;
   assign src_valid = (cnt_q != '0);
   assign src_data  = mem_q[rd_q];
   assign stored    = src_valid;

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= data;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + 1'b1;
         if (load) rd_q <= rd_q + 1'b1;
         if (push && !load)      cnt_q <= cnt_q + 1'b1;
         else if (load && !push) cnt_q <= cnt_q - 1'b1;
      end
   end
`else
   assign ready     = run_q && (state_q == S_IDLE);
   assign src_valid = valid && ready;
   assign src_data  = data;
   assign stored    = 1'b0;
`endif

   assign baud_tc = (baud_q == DIV_LAST);
   assign load    = src_valid && ((state_q == S_IDLE) || (state_q == S_STOP && baud_tc));
   assign tx      = tx_q;
   assign busy    = (state_q != S_IDLE) || stored;

   always_comb begin
      state_d = state_q;
      baud_d  = baud_tc ? 16'd0 : baud_q + 16'd1;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      case (state_q)
         S_IDLE: begin
            baud_d = 16'd0;
            tx_d   = 1'b1;
         end
         S_START: begin
            if (baud_tc) begin
               state_d = S_DATA;
               bit_d   = 3'd0;
               tx_d    = shift_q[0];
               shift_d = {1'b0, shift_q[7:1]};
            end
         end
         S_DATA: begin
            if (baud_tc) begin
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  tx_d    = shift_q[0];
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end
         end
         S_STOP: begin
            if (baud_tc) begin
               state_d = S_IDLE;
               tx_d    = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase
      // A load at the end of STOP chains straight into the next START bit
      if (load) begin
         state_d = S_START;
         baud_d  = 16'd0;
         bit_d   = 3'd0;
         shift_d = src_data;
         tx_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         run_q   <= 1'b1;
      end
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo at CLOCK_DIVIDER=4
module tb_uart_tx_fifo;
   logic       clk = 1'b0;
   logic       nrst = 1'b0;
   logic [7:0] data = 8'h00;
   logic       valid = 1'b0;
   logic       ready;
   logic       tx;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

`ifdef UART_TX_FIFO_EN
   localparam int OFF = 1;
`else
   localparam int OFF = 0;
`endif

   logic [7:0] exp_q[$];
   int         start_q[$];

   uart_tx_fifo #(.CLOCK_DIVIDER(4), .FIFO_DEPTH(4)) dut (
      .clk(clk), .nrst(nrst), .data(data), .valid(valid),
      .ready(ready), .tx(tx), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Line monitor: 4 samples per bit; every sample of a bit must agree with the frame level
   logic        mon_on = 1'b0;
   int          mon_k  = 0;
   logic [39:0] mon_s;
   always @(negedge clk) begin
      if (!nrst) begin
         mon_on = 1'b0;
      end else if (!mon_on) begin
         if (tx === 1'b0) begin
            mon_on   = 1'b1;
            mon_s[0] = tx;
            mon_k    = 1;
            start_q.push_back(cyc);
         end
      end else begin
         mon_s[mon_k] = tx;
         mon_k++;
         if (mon_k == 40) begin
            logic [7:0] got;
            logic       ok;
            logic [7:0] e;
            mon_on = 1'b0;
            ok = 1'b1;
            for (int i = 0; i < 8; i++) got[i] = mon_s[4 + 4*i];
            for (int s = 0; s < 40; s++) begin
               if (s < 4 && mon_s[s] !== 1'b0) ok = 1'b0;
               else if (s >= 36 && mon_s[s] !== 1'b1) ok = 1'b0;
               else if (s >= 4 && s < 36 && mon_s[s] !== got[(s/4)-1]) ok = 1'b0;
            end
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_frame: got byte %02h, required no frame", got);
            end else begin
               e = exp_q.pop_front();
               if (!ok || got !== e) begin
                  n_fail++;
                  $display("FAIL frame_byte: got %02h framing_ok=%0b, required %02h framing_ok=1", got, ok, e);
               end
            end
         end
      end
   end

   task automatic drain(output logic ok);
      int t = 0;
      while ((exp_q.size() != 0 || busy !== 1'b0) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      ok = (t < 3000);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_tests++;
         if (tx !== 1'b1 || busy !== 1'b0 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: tx=%b busy=%b ready=%b, required tx=1 busy=0 ready=0", tx, busy, ready);
         end
      end
      nrst = 1'b1;
      @(negedge clk);
      n_tests++;
      if (ready !== 1'b1 || tx !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: tx=%b busy=%b ready=%b, required tx=1 busy=0 ready=1", tx, busy, ready);
      end
   endtask

   task automatic test_single;
      logic       seq [128];
      logic [9:0] fr;
      logic       ok;
      int         n, acc;
      fr = {1'b1, 8'h55, 1'b0};
      start_q.delete();
      n_tests++;
      if (ready !== 1'b1) begin
         n_fail++;
         $display("FAIL single_ready: ready=%b, required 1", ready);
      end
      data = 8'h55;
      valid = 1'b1;
      exp_q.push_back(8'h55);
      acc = cyc + 1;
      @(negedge clk);
      valid = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         seq[n] = tx;
         n++;
         @(negedge clk);
      end
      n_tests++;
      if (n != 40 + OFF) begin
         n_fail++;
         $display("FAIL single_busy_len: %0d cycles, required %0d", n, 40 + OFF);
      end
      ok = (n >= 40 + OFF);
      for (int b = 0; b < 10 && ok; b++)
         for (int j = 0; j < 4; j++)
            if (seq[OFF + 4*b + j] !== fr[b]) ok = 1'b0;
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL single_tx_seq: tx pattern differs from 0,1,0,1,0,1,0,1,0,1 x4 cycles");
      end
      n_tests++;
      if (tx !== 1'b1) begin
         n_fail++;
         $display("FAIL single_tx_idle: tx=%b, required 1", tx);
      end
      drain(ok);
      n_tests++;
      if (!ok || start_q.size() != 1 || start_q[0] - acc != OFF) begin
         n_fail++;
         $display("FAIL single_latency: drained=%0b frames=%0d, required drained=1 frames=1 start offset %0d",
                  ok, start_q.size(), OFF);
      end
   endtask

   task automatic test_back_to_back;
`ifdef UART_TX_FIFO_EN
      localparam int NB = 6;
      logic [7:0] bytes [6] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      localparam int EXP_LOW = 37;
      localparam int EXP_GAP = 40;
`else
      localparam int NB = 2;
      logic [7:0] bytes [2] = '{8'hA3, 8'h3A};
      localparam int EXP_LOW = 40;
      localparam int EXP_GAP = 41;
`endif
      int   acc [8];
      int   i, t, low;
      logic ok;
      start_q.delete();
      i = 0; t = 0; low = 0;
      while (i < NB && t < 300) begin
         data = bytes[i];
         valid = 1'b1;
         if (ready === 1'b1) begin
            acc[i] = cyc + 1;
            exp_q.push_back(bytes[i]);
            i++;
         end else begin
            low++;
         end
         @(negedge clk);
         t++;
      end
      valid = 1'b0;
      n_tests++;
      if (i != NB) begin
         n_fail++;
         $display("FAIL b2b_accepts: %0d bytes accepted, required %0d", i, NB);
      end
      n_tests++;
      if (low != EXP_LOW) begin
         n_fail++;
         $display("FAIL b2b_ready_low: ready low %0d cycles, required %0d", low, EXP_LOW);
      end
`ifdef UART_TX_FIFO_EN
      n_tests++;
      if (i == NB && (acc[4] - acc[0] != 4 || acc[5] - acc[0] != 42)) begin
         n_fail++;
         $display("FAIL b2b_accept_times: byte4 +%0d byte5 +%0d, required +4 +42", acc[4] - acc[0], acc[5] - acc[0]);
      end
`else
      n_tests++;
      if (i == NB && acc[1] - acc[0] != 41) begin
         n_fail++;
         $display("FAIL b2b_accept_times: second accept +%0d, required +41", acc[1] - acc[0]);
      end
`endif
      drain(ok);
      n_tests++;
      if (!ok || start_q.size() != NB) begin
         n_fail++;
         $display("FAIL b2b_frames: drained=%0b frames=%0d, required drained=1 frames=%0d", ok, start_q.size(), NB);
      end else begin
         n_tests++;
         if (start_q[0] - acc[0] != OFF) begin
            n_fail++;
            $display("FAIL b2b_first_start: offset %0d, required %0d", start_q[0] - acc[0], OFF);
         end
         for (int k = 1; k < NB; k++) begin
            n_tests++;
            if (start_q[k] - start_q[k-1] != EXP_GAP) begin
               n_fail++;
               $display("FAIL b2b_gap: frame %0d start gap %0d, required %0d", k, start_q[k] - start_q[k-1], EXP_GAP);
            end
         end
      end
   endtask

   task automatic test_ignore;
      int   k;
      logic ok;
      k = 0;
      while (ready === 1'b1 && k < 8) begin
         data = 8'h90 + 8'(k);
         valid = 1'b1;
         exp_q.push_back(data);
         @(negedge clk);
         k++;
      end
      n_tests++;
      if (k != 1 + 4*OFF) begin
         n_fail++;
         $display("FAIL ignore_fill: %0d accepts before ready fell, required %0d", k, 1 + 4*OFF);
      end
      for (int c = 0; c < 30; c++) begin
         if (ready === 1'b1) begin
            valid = 1'b0;
         end else begin
            valid = 1'($urandom_range(0, 1));
            data  = 8'($urandom_range(0, 255));
         end
         @(negedge clk);
      end
      valid = 1'b0;
      drain(ok);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL ignore_drain: %0d expected bytes still pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_reset_midframe;
      int   t;
      logic ok;
      n_tests++;
      if (ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_ready: ready=%b, required 1", ready);
      end
      data = 8'h00;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      t = 0;
      while (tx !== 1'b0 && t < 10) begin
         @(negedge clk);
         t++;
      end
      repeat (21) @(negedge clk);
      n_tests++;
      if (tx !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_pre: tx=%b at data bit 4, required 0", tx);
      end
      #2 nrst = 1'b0;
      #1;
      n_tests++;
      if (tx !== 1'b1 || ready !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_async: tx=%b ready=%b busy=%b, required tx=1 ready=0 busy=0", tx, ready, busy);
      end
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      start_q.delete();
      @(negedge clk);
      n_tests++;
      if (ready !== 1'b1 || tx !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_release: ready=%b tx=%b, required 1 1", ready, tx);
      end
      data = 8'hFF;
      valid = 1'b1;
      exp_q.push_back(8'hFF);
      @(negedge clk);
      valid = 1'b0;
      drain(ok);
      n_tests++;
      if (!ok || start_q.size() != 1) begin
         n_fail++;
         $display("FAIL midrst_resend: drained=%0b frames=%0d, required 1 1", ok, start_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_ignore();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
